// File: rtl/kpn_fifo_reader.sv
// KPN consumer node: blocking reads from an upstream FIFO, one token in flight, valid/ready output.
// Optional running sum of accepted tokens on sum_out when KPN_READER_SUM_EN is defined.
module kpn_fifo_reader #(
  parameter int BITS_NUMBER = 16,
  parameter int TOKEN_COUNT = 4,
  parameter int COUNT_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   fifo_empty,
  input  logic [BITS_NUMBER-1:0] fifo_data,
  output logic                   fifo_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS_NUMBER-1:0] out_data,
  output logic [COUNT_BITS-1:0]  tokens_read,
  output logic                   busy,
  output logic                   done
`ifdef KPN_READER_SUM_EN
  ,
  output logic [BITS_NUMBER+COUNT_BITS-1:0] sum_out
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // REQ   | issue rd as soon as the FIFO is non-empty
  // WAIT  | FIFO read latency; fifo_data valid this cycle
  // HOLD  | token presented downstream until accepted
  // DONE  | one-cycle done pulse, then IDLE
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [COUNT_BITS-1:0] TC = COUNT_BITS'(TOKEN_COUNT);

  state_t                   state_q, state_d;
  logic                     out_valid_q, out_valid_d;
  logic [BITS_NUMBER-1:0]   out_data_q, out_data_d;
  logic [COUNT_BITS-1:0]    tokens_q, tokens_d;
  logic [COUNT_BITS-1:0]    tokens_inc;
  logic                     accept;
  logic                     last_tok;
  logic                     run_start;
`ifdef KPN_READER_SUM_EN
  logic [BITS_NUMBER+COUNT_BITS-1:0] sum_q, sum_d;
`endif

  assign tokens_inc = tokens_q + COUNT_BITS'(1);
  assign accept     = (state_q == S_HOLD) && out_valid_q && out_ready;
  assign last_tok   = (TOKEN_COUNT != 0) && (tokens_inc == TC);
  assign run_start  = (state_q == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      tokens_q    <= '0;
`ifdef KPN_READER_SUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      tokens_q    <= tokens_d;
`ifdef KPN_READER_SUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  if (!fifo_empty) state_d = S_WAIT;
      S_WAIT: state_d = S_HOLD;
      S_HOLD: if (accept) state_d = last_tok ? S_DONE : S_REQ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; the token is captured at the end of WAIT.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    tokens_d    = tokens_q;
    if (run_start) tokens_d = '0;
    if (state_q == S_WAIT) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_data;
    end
    if (accept) begin
      out_valid_d = 1'b0;
      tokens_d    = tokens_inc;
    end
  end

`ifdef KPN_READER_SUM_EN
  always_comb begin
    sum_d = sum_q;
    if (run_start) sum_d = '0;
    else if (accept) sum_d = sum_q + (BITS_NUMBER+COUNT_BITS)'(out_data_q);
  end
  assign sum_out = sum_q;
`endif

  always_comb begin
    fifo_rd = (state_q == S_REQ) && !fifo_empty;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign tokens_read = tokens_q;

endmodule
